// File: rtl/task_7_accum_adder.sv
// ---------------------------------------------------------------------------
// task_7_accum_adder
//
// Purpose:
//   Board-level switch adder/accumulator. Two WIDTH-bit switch operands are
//   added on a key1 press, the first operand is accumulated into the held
//   result on a key2 press, and key3 clears the result and both flags. Keys
//   are active-low, synchronised with two flops and edge-detected so that a
//   held key produces exactly one operation. Operand and result values are
//   shown on active-low seven-segment digits.
//
// Optional feature (macro SUB_EN):
//   When SUB_EN is defined and sub_mode is high in the pulse cycle, add
//   computes sw1 - sw2 and accumulate computes result - sw1. In that case
//   ledg8 reports the borrow (minuend < subtrahend) and ledr0 accumulates
//   borrows. Without SUB_EN the sub_mode pin is present but has no effect.
//
// Parameters:
//   WIDTH     operand/result width, multiple of 4 in the range 4..32
//   NDIG      hex digits per displayed value, fixed at WIDTH/4
//
// Ports:
//   clk       board clock, all state on the rising edge
//   key0_rst  asynchronous active-low reset
//   key1_add  active-low key: result <= sw1 + sw2
//   key2_acc  active-low key: result <= result + sw1
//   key3_clr  active-low key: clear result and flags
//   sub_mode  subtract select (only meaningful with SUB_EN)
//   sw1       operand A switches
//   sw2       operand B switches
//   ledg8     carry/borrow of the last operation
//   ledr0     sticky carry/borrow since the last clear or reset
//   hex_a     operand A digits, digit 0 at bits [6:0]
//   hex_b     operand B digits, digit 0 at bits [6:0]
//   hex_r     result digits, digit 0 at bits [6:0]
// ---------------------------------------------------------------------------
module task_7_accum_adder #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     key0_rst,
   input  logic                     key1_add,
   input  logic                     key2_acc,
   input  logic                     key3_clr,
   input  logic                     sub_mode,
   input  logic [WIDTH-1:0]         sw1,
   input  logic [WIDTH-1:0]         sw2,
   output logic                     ledg8,
   output logic                     ledr0,
   output logic [7*(WIDTH/4)-1:0]   hex_a,
   output logic [7*(WIDTH/4)-1:0]   hex_b,
   output logic [7*(WIDTH/4)-1:0]   hex_r
);

   localparam int NDIG = WIDTH / 4;

   // Key vector ordering used throughout: bit0 = add, bit1 = acc, bit2 = clr.
   logic [2:0]       keys_n;

   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       prev_q,  prev_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q,  carry_d;
   logic             ovf_q,    ovf_d;

   logic [2:0]       pulse;
   logic             do_clr;
   logic             do_add;
   logic             do_acc;
   logic             do_sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   op_res;

   assign keys_n = {key3_clr, key2_acc, key1_add};

   // Active-low seven-segment encoding, bit0 = segment a .. bit6 = segment g.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Key conditioning: two synchroniser stages then one history stage. A
   // press pulse is the synchronised level being low while the history is
   // still high, so a held key fires once and must be seen released before
   // it can fire again. Reset values of 1 (released) keep reset release
   // from looking like a press.
   always_comb begin
      sync1_d = keys_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      pulse   = ~sync2_q & prev_q;
   end

   // Operation select: clear beats add, add beats accumulate; a losing
   // pulse in the same cycle is simply dropped.
   always_comb begin
      do_clr = pulse[2];
      do_add = pulse[0] & ~pulse[2];
      do_acc = pulse[1] & ~pulse[0] & ~pulse[2];
`ifdef SUB_EN
      do_sub = sub_mode;
`else
      do_sub = sub_mode & 1'b0;
`endif
   end

   // Shared adder/subtractor. The extra top bit is the carry for addition
   // and the borrow for subtraction (it is set exactly when op_a < op_b).
   always_comb begin
      op_a   = do_add ? sw1 : result_q;
      op_b   = do_add ? sw2 : sw1;
      op_res = '0;
      if (do_sub) begin
         op_res = {1'b0, op_a} - {1'b0, op_b};
      end else begin
         op_res = {1'b0, op_a} + {1'b0, op_b};
      end
   end

   // Next-state for the result and LED flags; everything holds unless a
   // press pulse is present, so switch movement alone never changes them.
   always_comb begin
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      if (do_clr) begin
         result_d = '0;
         carry_d  = 1'b0;
         ovf_d    = 1'b0;
      end else if (do_add || do_acc) begin
         result_d = op_res[WIDTH-1:0];
         carry_d  = op_res[WIDTH];
         ovf_d    = ovf_q | op_res[WIDTH];
      end
   end

   // All state registers. Reset is asynchronous; its release is sampled
   // through the key synchronisers, which come out of reset released.
   always_ff @(posedge clk or negedge key0_rst) begin
      if (!key0_rst) begin
         sync1_q  <= 3'b111;
         sync2_q  <= 3'b111;
         prev_q   <= 3'b111;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ledg8 = carry_q;
   assign ledr0 = ovf_q;

   // Digit decoders: operands follow the live switches, the result follows
   // the result register. Digit 0 is the least significant nibble.
   for (genvar g = 0; g < NDIG; g++) begin : g_digit
      assign hex_a[7*g +: 7] = seg7(sw1[4*g +: 4]);
      assign hex_b[7*g +: 7] = seg7(sw2[4*g +: 4]);
      assign hex_r[7*g +: 7] = seg7(result_q[4*g +: 4]);
   end

endmodule

// File: tb/tb_task_7_accum_adder.sv
// ---------------------------------------------------------------------------
// tb_task_7_accum_adder
//
// Self-checking bench for task_7_accum_adder at WIDTH = 8. A reference
// model of result/carry/overflow pushes the expected display and LED state
// onto a scoreboard queue when a key press is driven; each scenario task
// pops and compares when the design is due to have updated.
// ---------------------------------------------------------------------------
module tb_task_7_accum_adder;

   typedef struct packed {
      logic [13:0] hex;
      logic        c;
      logic        o;
   } exp_t;

   logic        clk;
   logic        key0_rst;
   logic        key1_add;
   logic        key2_acc;
   logic        key3_clr;
   logic        sub_mode;
   logic [7:0]  sw1;
   logic [7:0]  sw2;
   logic        ledg8;
   logic        ledr0;
   logic [13:0] hex_a;
   logic [13:0] hex_b;
   logic [13:0] hex_r;

   exp_t        sb[$];
   exp_t        obs;
   exp_t        expv;
   exp_t        prev;
   logic [7:0]  m_r;
   logic        m_c;
   logic        m_o;
   int          cmp_count;
   int          err_count;

   task_7_accum_adder #(.WIDTH(8)) dut (
      .clk      (clk),
      .key0_rst (key0_rst),
      .key1_add (key1_add),
      .key2_acc (key2_acc),
      .key3_clr (key3_clr),
      .sub_mode (sub_mode),
      .sw1      (sw1),
      .sw2      (sw2),
      .ledg8    (ledg8),
      .ledr0    (ledr0),
      .hex_a    (hex_a),
      .hex_b    (hex_b),
      .hex_r    (hex_r)
   );

   // 100 MHz board clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference digit table (active-low, bit0 = segment a)
   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
         4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
         4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   function automatic exp_t cur_exp();
      return {seg(m_r[7:4]), seg(m_r[3:0]), m_c, m_o};
   endfunction

   // Reference model: op 0 = clear, 1 = add, 2 = accumulate
   task automatic model_op(input int op, input logic sub);
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] t;
      if (op == 0) begin
         m_r = 8'h00;
         m_c = 1'b0;
         m_o = 1'b0;
      end else begin
         a = (op == 1) ? sw1 : m_r;
         b = (op == 1) ? sw2 : sw1;
         t = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
         m_r = t[7:0];
         m_c = t[8];
         m_o = m_o | t[8];
      end
      sb.push_back(cur_exp());
   endtask

   // Hold the masked keys low across two rising edges, then release;
   // the design updates on the next rising edge after this returns.
   task automatic applyStimulus(input logic [2:0] mask);
      @(negedge clk);
      {key3_clr, key2_acc, key1_add} = ~mask;
      repeat (2) @(negedge clk);
      {key3_clr, key2_acc, key1_add} = 3'b111;
   endtask

   task automatic wait_update();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      key0_rst = 1'b0;
      #3;
      obs = {hex_r, ledg8, ledr0};
      cmp_count++;
      if (obs !== {7'h40, 7'h40, 1'b0, 1'b0}) begin
         err_count++;
         $display("[TB] FAIL reset_state: got %h want %h", obs, {7'h40, 7'h40, 2'b00});
      end
      repeat (2) @(negedge clk);
      key0_rst = 1'b1;
      repeat (5) @(negedge clk);
      obs = {hex_r, ledg8, ledr0};
      cmp_count++;
      if (obs !== {7'h40, 7'h40, 1'b0, 1'b0}) begin
         err_count++;
         $display("[TB] FAIL reset_release: got %h want %h", obs, {7'h40, 7'h40, 2'b00});
      end
   endtask

   task automatic test_operand_digits();
      sw1 = 8'hA3;
      sw2 = 8'hE7;
      #1;
      cmp_count++;
      if (hex_a !== {7'h08, 7'h30}) begin
         err_count++;
         $display("[TB] FAIL hex_a_A3: got %h want %h", hex_a, {7'h08, 7'h30});
      end
      cmp_count++;
      if (hex_b !== {7'h06, 7'h78}) begin
         err_count++;
         $display("[TB] FAIL hex_b_E7: got %h want %h", hex_b, {7'h06, 7'h78});
      end
   endtask

   task automatic test_add();
      logic [7:0] a_tab [3];
      logic [7:0] b_tab [3];
      a_tab = '{8'h04, 8'hF4, 8'h01};
      b_tab = '{8'h03, 8'hF3, 8'h01};
      for (int i = 0; i < 3; i++) begin
         sw1 = a_tab[i];
         sw2 = b_tab[i];
         model_op(1, 1'b0);
         applyStimulus(3'b001);
         wait_update();
         obs  = {hex_r, ledg8, ledr0};
         expv = sb.pop_front();
         cmp_count++;
         if (obs !== expv) begin
            err_count++;
            $display("[TB] FAIL add_%0d (%h+%h): got %h want %h", i, a_tab[i], b_tab[i], obs, expv);
         end
      end
   endtask

   task automatic test_accumulate();
      applyStimulus(3'b100);
      model_op(0, 1'b0);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== expv) begin
         err_count++;
         $display("[TB] FAIL acc_clear1: got %h want %h", obs, expv);
      end
      sw1 = 8'h04;
      sw2 = 8'h03;
      model_op(1, 1'b0);
      applyStimulus(3'b001);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== {7'h40, 7'h78, 2'b00} || obs !== expv) begin
         err_count++;
         $display("[TB] FAIL acc_add_07: got %h want %h", obs, expv);
      end
      sw1 = 8'hFA;
      model_op(2, 1'b0);
      applyStimulus(3'b010);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== {7'h40, 7'h79, 2'b11} || obs !== expv) begin
         err_count++;
         $display("[TB] FAIL acc_wrap_01: got %h want %h", obs, expv);
      end
      model_op(0, 1'b0);
      applyStimulus(3'b100);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== expv) begin
         err_count++;
         $display("[TB] FAIL acc_clear2: got %h want %h", obs, expv);
      end
   endtask

   task automatic test_priority();
      logic [2:0] masks [3];
      int         ops   [3];
      masks = '{3'b101, 3'b011, 3'b110};
      ops   = '{0, 1, 0};
      sw1 = 8'h10;
      sw2 = 8'h20;
      model_op(1, 1'b0);
      applyStimulus(3'b001);
      wait_update();
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         model_op(ops[i], 1'b0);
         applyStimulus(masks[i]);
         wait_update();
         obs  = {hex_r, ledg8, ledr0};
         expv = sb.pop_front();
         cmp_count++;
         if (obs !== expv) begin
            err_count++;
            $display("[TB] FAIL priority_mask_%b: got %h want %h", masks[i], obs, expv);
         end
      end
   endtask

   task automatic test_hold_latency();
      sw1  = 8'h12;
      sw2  = 8'h34;
      prev = cur_exp();
      model_op(1, 1'b0);
      @(negedge clk);
      key1_add = 1'b0;
      for (int e = 0; e < 2; e++) begin
         wait_update();
         obs = {hex_r, ledg8, ledr0};
         cmp_count++;
         if (obs !== prev) begin
            err_count++;
            $display("[TB] FAIL early_update_edge_k+%0d: got %h want %h", e, obs, prev);
         end
      end
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== expv) begin
         err_count++;
         $display("[TB] FAIL update_edge_k+2: got %h want %h", obs, expv);
      end
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         sw2 = 8'($urandom);
         wait_update();
         obs = {hex_r, ledg8, ledr0};
         cmp_count++;
         if (obs !== expv) begin
            err_count++;
            $display("[TB] FAIL held_key_cycle_%0d: got %h want %h", i, obs, expv);
         end
      end
      @(negedge clk);
      key1_add = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a_tab [3];
      a_tab = '{8'h05, 8'h05, 8'hFB};
      model_op(0, 1'b0);
      applyStimulus(3'b100);
      wait_update();
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         sw1 = a_tab[i];
         model_op(2, 1'b0);
         applyStimulus(3'b010);
         wait_update();
         obs  = {hex_r, ledg8, ledr0};
         expv = sb.pop_front();
         cmp_count++;
         if (obs !== expv) begin
            err_count++;
            $display("[TB] FAIL b2b_acc_%0d: got %h want %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      @(negedge clk);
      key2_acc = 1'b0;
      @(negedge clk);
      key0_rst = 1'b0;
      #1;
      obs = {hex_r, ledg8, ledr0};
      cmp_count++;
      if (obs !== {7'h40, 7'h40, 2'b00}) begin
         err_count++;
         $display("[TB] FAIL reset_mid_press: got %h want %h", obs, {7'h40, 7'h40, 2'b00});
      end
      @(negedge clk);
      key2_acc = 1'b1;
      @(negedge clk);
      key0_rst = 1'b1;
      m_r = 8'h00;
      m_c = 1'b0;
      m_o = 1'b0;
      repeat (5) @(negedge clk);
      obs = {hex_r, ledg8, ledr0};
      cmp_count++;
      if (obs !== {7'h40, 7'h40, 2'b00}) begin
         err_count++;
         $display("[TB] FAIL reset_mid_press_after: got %h want %h", obs, {7'h40, 7'h40, 2'b00});
      end
   endtask

   task automatic test_sub_mode();
      logic sub_active;
`ifdef SUB_EN
      sub_active = 1'b1;
`else
      sub_active = 1'b0;
`endif
      sub_mode = 1'b1;
      sw1 = 8'h03;
      sw2 = 8'h04;
      model_op(1, sub_active);
      applyStimulus(3'b001);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== expv) begin
         err_count++;
         $display("[TB] FAIL sub_mode_add: got %h want %h", obs, expv);
      end
      sw1 = 8'h0F;
      model_op(2, sub_active);
      applyStimulus(3'b010);
      wait_update();
      obs  = {hex_r, ledg8, ledr0};
      expv = sb.pop_front();
      cmp_count++;
      if (obs !== expv) begin
         err_count++;
         $display("[TB] FAIL sub_mode_acc: got %h want %h", obs, expv);
      end
      sub_mode = 1'b0;
   endtask

   initial begin
      cmp_count = 0;
      err_count = 0;
      key0_rst  = 1'b0;
      key1_add  = 1'b1;
      key2_acc  = 1'b1;
      key3_clr  = 1'b1;
      sub_mode  = 1'b0;
      sw1       = 8'h00;
      sw2       = 8'h00;
      m_r       = 8'h00;
      m_c       = 1'b0;
      m_o       = 1'b0;

      test_reset();
      test_operand_digits();
      test_add();
      test_accumulate();
      test_priority();
      test_hold_latency();
      test_back_to_back();
      test_reset_mid_press();
      test_sub_mode();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule

// File: doc/task_7_accum_adder.md
# task_7_accum_adder

Parametrised successor to the two-operand switch adder for the board-level task set. Adds two WIDTH-bit switch operands, or accumulates the first operand into a held result, on debounced-free, synchronised key presses. Drives operand and result seven-segment digits plus carry/overflow LEDs. Sits directly on board pins: keys, switches, HEX displays, green/red LEDs.

## Interface
- WIDTH, 8, operand/result width; multiple of 4, range 4..32
- NDIG, WIDTH/4, hex digits per displayed value (derived, not overridden)
- clk  in  1  board clock, all state on rising edge
- key0_rst  in  1  asynchronous, active-low reset
- key1_add  in  1  active-low key: result <= sw1 + sw2
- key2_acc  in  1  active-low key: result <= result + sw1
- key3_clr  in  1  active-low key: clear result and flags
- sub_mode  in  1  select subtract (used only with SUB_EN)
- sw1  in  WIDTH  operand A
- sw2  in  WIDTH  operand B
- ledg8  out  1  carry/borrow of last operation
- ledr0  out  1  sticky overflow (any carry/borrow since last clear)
- hex_a  out  7*NDIG  operand A digits
- hex_b  out  7*NDIG  operand B digits
- hex_r  out  7*NDIG  result digits

## Operation
- Each key1..3: two-flop synchroniser (reset value 1 = released), then one prev flop; press pulse = synced low AND prev high. Holding a key yields exactly one pulse.
- Priority on same-cycle pulses: clr > add > acc; lower-priority pulse discarded.
- add: {ledg8, result} <= sw1 + sw2 (WIDTH+1-bit sum); ledr0 <= ledr0 | carry.
- acc: {ledg8, result} <= result + sw1; ledr0 <= ledr0 | carry.
- clr: result <= 0, ledg8 <= 0, ledr0 <= 0.
- No pulse: all registers hold. Switch changes alone never alter result.
- Digit encoding: 7 bits per digit, bit0 = segment a .. bit6 = g, active-low (0=7'h40, 1=7'h79, 3=7'h30, 4=7'h19, 7=7'h78, A=7'h08, E=7'h06, F=7'h0E). Digit 0 (least significant nibble) at bits [6:0].
- hex_a/hex_b combinational from live switches; hex_r combinational from result register.

## Timing
- Reset (key0_rst low, async): all sync/prev flops 1, result 0, ledg8 0, ledr0 0; hex_r all 7'h40. Release is sampled synchronously; no pulse may be generated by reset release.
- Latency: key first sampled low at edge k; pulse during cycle after edge k+1; result/LEDs update at edge k+2; hex_r valid immediately after.
- Minimum press: key low across 2 consecutive edges; shorter glitches may be missed.
- Re-press: key must be sampled high at least one edge before next press registers.
- Reset asserted mid-pulse: pulse discarded, all state to reset values.
- Wrap-around: result modulo 2^WIDTH; carry only via ledg8/ledr0.

## Configuration
- SUB_EN defined: when sub_mode=1, add computes sw1 - sw2, acc computes result - sw1; ledg8 = borrow (minuend < subtrahend); ledr0 accumulates borrows. sub_mode sampled in the pulse cycle; sub_mode=0 behaves as without macro.
- SUB_EN undefined: sub_mode port present but ignored; only addition.

## Test plan
- Reset, then sw1=8'h04, sw2=8'h03, press key1 -> result 8'h07, ledg8=0, ledr0=0, hex_r={7'h40,7'h78}.
- sw1=8'hF4, sw2=8'hF3, press key1 -> result 8'hE7, ledg8=1, ledr0=1, hex_r digit0=7'h78, digit1=7'h06.
- From result 8'h07, clear then press key1 (8'h04+8'h03), then sw1=8'hFA, press key2 -> result 8'h01, ledg8=1, ledr0=1; press key3 -> result 0, both LEDs 0.
- Hold key1 low 20 cycles while changing sw2 -> single update at edge k+2, result unchanged thereafter; key1 and key3 pulses same cycle -> cleared.
- Assert key0_rst one cycle after key2 goes low -> no accumulate, result 0, hex_r all 7'h40.
- SUB_EN, sub_mode=1, sw1=8'h03, sw2=8'h04, press key1 -> result 8'hFF, ledg8=1, ledr0=1; WIDTH=16 build: 16'hFFFF+16'h0001 -> 16'h0000, ledg8=1.
